// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: instruction-memory request channel and decoded-instruction stream.
// The master modport is the fetch queue side.
interface fetch_queue_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [DW-1:0] imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;

    modport master (
        output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch unit: one outstanding imem request, branch/jump redirect with flush, FIFO of fetched words.
// Optional FETCH_BYPASS_EN: an ack arriving at an empty queue is presented on inst_* in the same cycle.
module fetch_queue #(
    parameter int unsigned   AW       = 32,
    parameter int unsigned   DW       = 32,
    parameter int unsigned   DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          Z,
    input  logic          B,
    input  logic [AW-1:0] B_addr,
    input  logic [AW-1:0] br_pc,
    input  logic          J,
    input  logic [AW-1:0] J_addr,
    output logic [AW-1:0] addr,
    fetch_queue_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [AW-1:0] pc, req_addr, target;
    logic [CW-1:0] count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          redirect, issue, push, store, pop, empty;

    logic [DW-1:0] data_mem [DEPTH];
    logic [AW-1:0] pc_mem   [DEPTH];

    assign redirect = J | (B & Z);
    assign target   = J ? J_addr : (br_pc + AW'(4) + (B_addr << 2));
    assign issue    = (state == IDLE) && (count < CW'(DEPTH)) && !redirect;
    assign push     = (state == REQ) && bus.imem_ack && !redirect && !rst;
    assign empty    = (count == '0);

    assign addr          = pc;
    assign bus.imem_req  = !rst && (state != IDLE);
    // Latched at issue so the request address holds even if a redirect moves pc.
    assign bus.imem_addr = req_addr;

`ifdef FETCH_BYPASS_EN
    logic bypass;
    assign bypass         = empty && push;
    assign store          = push && !(bypass && bus.inst_ready);
    assign pop            = !rst && !empty && bus.inst_ready;
    assign bus.inst_valid = !rst && (!empty || bypass);
    assign bus.inst_data  = empty ? bus.imem_rdata : data_mem[rd_ptr];
    assign bus.inst_pc    = empty ? pc : pc_mem[rd_ptr];
`else
    assign store          = push;
    assign pop            = !rst && !empty && bus.inst_ready;
    assign bus.inst_valid = !rst && !empty;
    assign bus.inst_data  = data_mem[rd_ptr];
    assign bus.inst_pc    = pc_mem[rd_ptr];
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = REQ;
            REQ: begin
                if (bus.imem_ack)  state_nxt = IDLE;
                else if (redirect) state_nxt = DROP;
            end
            DROP: if (bus.imem_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // PC, request address, queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (issue) req_addr <= pc;
            if (redirect) begin
                pc     <= target;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)  pc     <= pc + AW'(4);
                if (store) wr_ptr <= wr_ptr + PW'(1);
                if (pop)   rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(store) - CW'(pop);
            end
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        if (store) begin
            data_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue; memory returns addr ^ KEY unless a data override is active.
// Build with FETCH_BYPASS_EN defined to exercise the same-cycle bypass path.
module tb_fetch_queue;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    logic        clk;
    logic        rst;
    logic        Z, B, J;
    logic [31:0] B_addr, br_pc, J_addr, addr;
    logic        ack_en, ovr_en;
    logic [31:0] ovr_data;
    int          n_cmp;
    int          n_fail;

    fetch_queue_if #(.AW(32), .DW(32)) bus ();

    fetch_queue #(.AW(32), .DW(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk    (clk),
        .rst    (rst),
        .Z      (Z),
        .B      (B),
        .B_addr (B_addr),
        .br_pc  (br_pc),
        .J      (J),
        .J_addr (J_addr),
        .addr   (addr),
        .bus    (bus.master)
    );

    assign bus.imem_ack   = ack_en & bus.imem_req;
    assign bus.imem_rdata = ovr_en ? ovr_data : (bus.imem_addr ^ KEY);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        Z = 0; B = 0; J = 0; B_addr = '0; br_pc = '0; J_addr = '0;
        ack_en = 0; ovr_en = 0; ovr_data = '0; bus.inst_ready = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1;
        ack_en = 1;
        tick();
        tick();
        n_cmp++; if (addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected %h", addr, 32'h0); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.inst_valid); end
        rst = 0;
        ack_en = 0;
    endtask

    task automatic test_sequential;
        logic [31:0] got_pc [4];
        logic [31:0] got_dat [4];
        logic [31:0] req_a [4];
        logic [31:0] req_pc [4];
        int n = 0;
        int r = 0;
        for (int i = 0; i < 4; i++) begin
            got_pc[i] = '1; got_dat[i] = '1; req_a[i] = '1; req_pc[i] = '0;
        end
        do_reset();
        bus.inst_ready = 1;
        ack_en = 1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (bus.imem_req && bus.imem_ack && r < 4) begin
                req_a[r] = bus.imem_addr; req_pc[r] = addr; r++;
            end
            if (bus.inst_valid && bus.inst_ready) begin
                got_pc[n] = bus.inst_pc; got_dat[n] = bus.inst_data; n++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got_pc[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, got_pc[i], 32'(i * 4)); end
            n_cmp++; if (got_dat[i] !== (32'(i * 4) ^ KEY)) begin n_fail++; $display("FAIL seq_data[%0d]: got %h expected %h", i, got_dat[i], 32'(i * 4) ^ KEY); end
            n_cmp++; if (req_a[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_imem_addr[%0d]: got %h expected %h", i, req_a[i], 32'(i * 4)); end
            n_cmp++; if (req_pc[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL seq_addr[%0d]: got %h expected %h", i, req_pc[i], 32'(i * 4)); end
        end
        clear_inputs();
    endtask

    task automatic test_full;
        int acks = 0;
        int n = 0;
        logic [31:0] got_pc [4];
        for (int i = 0; i < 4; i++) got_pc[i] = '1;
        do_reset();
        ack_en = 1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.imem_req && bus.imem_ack) acks++;
        end
        n_cmp++; if (acks !== 4) begin n_fail++; $display("FAIL full_fill_count: got %0d expected 4", acks); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_no_req: got %b expected 0", bus.imem_req); end
        n_cmp++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL full_head_pc: got %h expected %h", bus.inst_pc, 32'h0); end
        bus.inst_ready = 1;
        tick();
        bus.inst_ready = 0;
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.imem_req && bus.imem_ack) acks++;
            tick();
        end
        n_cmp++; if (acks !== 1) begin n_fail++; $display("FAIL full_refill_count: got %0d expected 1", acks); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL full_refill_req: got %b expected 0", bus.imem_req); end
        bus.inst_ready = 1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (bus.inst_valid && bus.inst_ready) begin got_pc[n] = bus.inst_pc; n++; end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (got_pc[i] !== 32'(4 + i * 4)) begin n_fail++; $display("FAIL full_drain_pc[%0d]: got %h expected %h", i, got_pc[i], 32'(4 + i * 4)); end
        end
        clear_inputs();
    endtask

    task automatic test_branch;
        int n = 0;
        do_reset();
        ack_en = 1;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            if (bus.imem_req && bus.imem_ack) n++;
        end
        tick();
        ack_en = 0;
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL br_pending_addr: got %h expected %h", bus.imem_addr, 32'h8); end
        n_cmp++; if (bus.inst_valid !== 1'b1) begin n_fail++; $display("FAIL br_pre_valid: got %b expected 1", bus.inst_valid); end
        B = 1; Z = 1; br_pc = 32'h10; B_addr = 32'd3;
        tick();
        B = 0; Z = 0;
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush_valid: got %b expected 0", bus.inst_valid); end
        n_cmp++; if (addr !== 32'h20) begin n_fail++; $display("FAIL br_target_addr: got %h expected %h", addr, 32'h20); end
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin n_fail++; $display("FAIL br_req_hold: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'h8); end
        ack_en = 1;
        tick();
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL br_late_ack_dropped: got %b expected 0", bus.inst_valid); end
        n_cmp++; if (addr !== 32'h20) begin n_fail++; $display("FAIL br_addr_after_drop: got %h expected %h", addr, 32'h20); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL br_next_req: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'h20); end
        tick();
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h20) begin n_fail++; $display("FAIL br_first_inst: got valid=%b pc=%h expected valid=1 pc=%h", bus.inst_valid, bus.inst_pc, 32'h20); end
        n_cmp++; if (bus.inst_data !== (32'h20 ^ KEY)) begin n_fail++; $display("FAIL br_first_data: got %h expected %h", bus.inst_data, 32'h20 ^ KEY); end
        clear_inputs();
    endtask

    task automatic test_jump;
        do_reset();
        J = 1; J_addr = 32'h100; B = 1; Z = 1; br_pc = 32'h10; B_addr = 32'd3;
        tick();
        J = 0; B = 0; Z = 0;
        n_cmp++; if (addr !== 32'h100) begin n_fail++; $display("FAIL jmp_priority_addr: got %h expected %h", addr, 32'h100); end
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL jmp_idle_no_req: got %b expected 0", bus.imem_req); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin n_fail++; $display("FAIL jmp_next_req: got req=%b addr=%h expected req=1 addr=%h", bus.imem_req, bus.imem_addr, 32'h100); end
        ack_en = 1; J = 1; J_addr = 32'h200;
        tick();
        J = 0; ack_en = 0;
        n_cmp++; if (addr !== 32'h200 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL jmp_ack_same_cycle: got addr=%h req=%b expected addr=%h req=0", addr, bus.imem_req, 32'h200); end
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL jmp_ack_discarded: got %b expected 0", bus.inst_valid); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h200) begin n_fail++; $display("FAIL jmp_req_after_ack: got %h expected %h", bus.imem_addr, 32'h200); end
        clear_inputs();
    endtask

    task automatic test_not_taken;
        logic [31:0] got_pc [3];
        int n = 0;
        for (int i = 0; i < 3; i++) got_pc[i] = '1;
        do_reset();
        B = 1; Z = 0; br_pc = 32'h10; B_addr = 32'd3;
        bus.inst_ready = 1;
        ack_en = 1;
        for (int c = 0; c < 30 && n < 3; c++) begin
            tick();
            if (bus.inst_valid && bus.inst_ready) begin got_pc[n] = bus.inst_pc; n++; end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (got_pc[i] !== 32'(i * 4)) begin n_fail++; $display("FAIL nt_pc[%0d]: got %h expected %h", i, got_pc[i], 32'(i * 4)); end
        end
        clear_inputs();
    endtask

    task automatic test_ack_latency;
        do_reset();
        bus.inst_ready = 1;
        tick();
        ovr_en = 1; ovr_data = 32'hDEAD_BEEF; ack_en = 1;
        #1;
`ifdef FETCH_BYPASS_EN
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL byp_same_cycle: got valid=%b data=%h expected valid=1 data=deadbeef", bus.inst_valid, bus.inst_data); end
        n_cmp++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL byp_pc: got %h expected %h", bus.inst_pc, 32'h0); end
        tick();
        ack_en = 0; ovr_en = 0;
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL byp_not_stored: got %b expected 0", bus.inst_valid); end
`else
        n_cmp++; if (bus.inst_valid !== 1'b0) begin n_fail++; $display("FAIL lat_ack_cycle: got %b expected 0", bus.inst_valid); end
        tick();
        ack_en = 0; ovr_en = 0;
        n_cmp++; if (bus.inst_valid !== 1'b1 || bus.inst_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat_next_cycle: got valid=%b data=%h expected valid=1 data=deadbeef", bus.inst_valid, bus.inst_data); end
        n_cmp++; if (bus.inst_pc !== 32'h0) begin n_fail++; $display("FAIL lat_pc: got %h expected %h", bus.inst_pc, 32'h0); end
`endif
        clear_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_full();
        test_branch();
        test_jump();
        test_not_taken();
        test_ack_latency();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
